// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame shape and line idle level.
// Used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam int   STOP_BITS  = 1;
    localparam int   FRAME_BITS = 1 + DATA_BITS + STOP_BITS;
    localparam logic LINE_IDLE  = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; read data is the combinational head entry.
// Push while full and pop while empty are ignored internally.
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready write port into a FIFO, serialised on tx
// using an internal baud divider; back-to-back frames are sent with no idle gap.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int DATA_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_t       state;
    uart_state_t       state_next;
    logic              tx_next;
    logic              busy_next;
    logic [15:0]       baud_cnt;
    logic [15:0]       baud_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_next;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_next;
    logic [DATA_W-1:0] head;
    logic              pop;
    logic              full;
    logic              empty;
    logic              baud_done;

    // wr_ready depends only on registered FIFO state, so a same-edge pop cannot free a slot.
    assign wr_ready = !full;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_valid && wr_ready),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tx       <= LINE_IDLE;
            tx_busy  <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_next;
            tx       <= tx_next;
            tx_busy  <= busy_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
        end
    end

    // Transitions only happen on a baud terminal count, so the wrap to 0 doubles as the
    // counter clear on state entry.
    always_comb begin
        state_next = state;
        tx_next    = tx;
        busy_next  = tx_busy;
        baud_next  = baud_done ? 16'd0 : baud_cnt + 16'd1;
        bit_next   = bit_idx;
        shift_next = shift;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                baud_next = 16'd0;
                tx_next   = LINE_IDLE;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    state_next = START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                if (baud_done) begin
                    state_next = DATA;
                    tx_next    = shift[0];
                    bit_next   = 3'd0;
                end
            end
            DATA: begin
                if (baud_done) begin
                    if (bit_idx == LAST_BIT) begin
                        state_next = STOP;
                        tx_next    = LINE_IDLE;
                    end else begin
                        shift_next = shift >> 1;
                        tx_next    = shift[1];
                        bit_next   = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = head;
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = LINE_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule
